// File: rtl/pong_frame_ctrl.sv
// pong_frame_ctrl: custom-instruction front end and per-frame game engine for
// a two-bar pong game. Bar positions are written into shadow registers and only
// become visible at the start of vertical blanking, so the picture never tears.
// Each frame the engine commits pending bars, moves the ball, then resolves
// walls, bar hits and misses.
module pong_frame_ctrl #(
    parameter int BAR1_X = 20,
    parameter int BAR2_X = 620,
    parameter int BAR_W  = 10,
    parameter int BAR_H  = 60,
    parameter int BALL_S = 8,
    parameter int STEP   = 2
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        CLK_EN,
    input  logic        START,
    input  logic [31:0] dataa,
    input  logic        i_frame_end,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic [9:0]  o_ybar1,
    output logic [9:0]  o_ybar2,
    output logic [9:0]  o_ball_x,
    output logic [8:0]  o_ball_y
);

    typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_MOVE, ST_BOUNCE} state_e;

    localparam logic [1:0] OP_BAR1   = 2'b00;
    localparam logic [1:0] OP_BAR2   = 2'b01;
    localparam logic [1:0] OP_STATUS = 2'b10;
    localparam logic [1:0] OP_RESET  = 2'b11;

    localparam logic [9:0] YBAR_MAX  = 10'(480 - BAR_H);
    localparam logic [9:0] YBAR_INIT = 10'd210;
    localparam logic [9:0] X_CENTER  = 10'((640 - BALL_S) / 2);
    localparam logic [8:0] Y_CENTER  = 9'((480 - BALL_S) / 2);

    // Signed 11-bit geometry so a step past the left/top edge stays negative.
    localparam logic signed [10:0] S_ZERO    = 11'sd0;
    localparam logic signed [10:0] S_STEP    = 11'(STEP);
    localparam logic signed [10:0] Y_LIMIT   = 11'(480 - BALL_S);
    localparam logic signed [10:0] X_LIMIT   = 11'(640 - BALL_S);
    localparam logic signed [10:0] BAR1_EDGE = 11'(BAR1_X + BAR_W);
    localparam logic signed [10:0] BAR2_EDGE = 11'(BAR2_X - BALL_S);
    localparam logic [10:0]        BALL_SPAN = 11'(BALL_S);
    localparam logic [10:0]        BAR_SPAN  = 11'(BAR_H);

    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic [31:0]        result_q, result_d;
    logic [9:0]         ybar1_q, ybar1_d, ybar2_q, ybar2_d;
    logic [9:0]         shadow1_q, shadow1_d, shadow2_q, shadow2_d;
    logic               pend1_q, pend1_d, pend2_q, pend2_d;
    logic [3:0]         score1_q, score1_d, score2_q, score2_d;
    logic [9:0]         ball_x_q, ball_x_d;
    logic [8:0]         ball_y_q, ball_y_d;
    logic               dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic signed [10:0] nx_q, nx_d, ny_q, ny_d;

    logic               accept;
    logic [9:0]         clamped;
    logic [8:0]         y_new;
    logic               dy_new;
    logic [10:0]        y_ext;
    logic               overlap1, overlap2, hit1, hit2;
    logic               unused_dataa;

    assign accept       = CLK_EN & START;
    assign clamped      = (dataa[9:0] > YBAR_MAX) ? YBAR_MAX : dataa[9:0];
    assign unused_dataa = ^dataa[29:10];

    // Next-state logic: frame sequencing first, then the command, which may
    // override frame updates (reset game) or re-arm a pending flag just cleared.
    always_comb begin
        // NOTE: every _d gets a default up front so no path can infer a latch.
        state_d   = state_q;
        done_d    = accept;
        result_d  = '0;
        ybar1_d   = ybar1_q;
        ybar2_d   = ybar2_q;
        shadow1_d = shadow1_q;
        shadow2_d = shadow2_q;
        pend1_d   = pend1_q;
        pend2_d   = pend2_q;
        score1_d  = score1_q;
        score2_d  = score2_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        y_new     = ball_y_q;
        dy_new    = dy_neg_q;
        y_ext     = '0;
        overlap1  = 1'b0;
        overlap2  = 1'b0;
        hit1      = 1'b0;
        hit2      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_frame_end) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (pend1_q) begin
                    ybar1_d = shadow1_q;
                    pend1_d = 1'b0;
                end
                if (pend2_q) begin
                    ybar2_d = shadow2_q;
                    pend2_d = 1'b0;
                end
                state_d = ST_MOVE;
            end
            ST_MOVE: begin
                nx_d    = dx_neg_q ? $signed({1'b0, ball_x_q}) - S_STEP
                                   : $signed({1'b0, ball_x_q}) + S_STEP;
                ny_d    = dy_neg_q ? $signed({2'b00, ball_y_q}) - S_STEP
                                   : $signed({2'b00, ball_y_q}) + S_STEP;
                state_d = ST_BOUNCE;
            end
            ST_BOUNCE: begin
                if (ny_q <= S_ZERO) begin
                    y_new  = '0;
                    dy_new = 1'b0;
                end else if (ny_q >= Y_LIMIT) begin
                    y_new  = Y_LIMIT[8:0];
                    dy_new = 1'b1;
                end else begin
                    y_new  = ny_q[8:0];
                    dy_new = dy_neg_q;
                end
                y_ext    = {2'b00, y_new};
                overlap1 = (y_ext + BALL_SPAN > {1'b0, ybar1_q}) &&
                           (y_ext < {1'b0, ybar1_q} + BAR_SPAN);
                overlap2 = (y_ext + BALL_SPAN > {1'b0, ybar2_q}) &&
                           (y_ext < {1'b0, ybar2_q} + BAR_SPAN);
                hit1     = dx_neg_q && (nx_q <= BAR1_EDGE) && overlap1;
                hit2     = !dx_neg_q && (nx_q >= BAR2_EDGE) && overlap2;

                if (hit1) begin
                    ball_x_d = BAR1_EDGE[9:0];
                    ball_y_d = y_new;
                    dx_neg_d = 1'b0;
                    dy_neg_d = dy_new;
                end else if (hit2) begin
                    ball_x_d = BAR2_EDGE[9:0];
                    ball_y_d = y_new;
                    dx_neg_d = 1'b1;
                    dy_neg_d = dy_new;
                end else if (nx_q <= S_ZERO) begin
                    score2_d = (score2_q == 4'hF) ? score2_q : score2_q + 4'd1;
                    ball_x_d = X_CENTER;
                    ball_y_d = Y_CENTER;
                    dx_neg_d = ~dx_neg_q;
                end else if (nx_q >= X_LIMIT) begin
                    score1_d = (score1_q == 4'hF) ? score1_q : score1_q + 4'd1;
                    ball_x_d = X_CENTER;
                    ball_y_d = Y_CENTER;
                    dx_neg_d = ~dx_neg_q;
                end else begin
                    ball_x_d = nx_q[9:0];
                    ball_y_d = y_new;
                    dy_neg_d = dy_new;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            unique case (dataa[31:30])
                OP_BAR1: begin
                    shadow1_d = clamped;
                    pend1_d   = 1'b1;
                    result_d  = {22'd0, clamped};
                end
                OP_BAR2: begin
                    shadow2_d = clamped;
                    pend2_d   = 1'b1;
                    result_d  = {22'd0, clamped};
                end
                OP_STATUS: begin
                    result_d = {score1_q, score2_q, 2'b00, pend2_q, pend1_q,
                                ybar2_q, ybar1_q};
                end
                OP_RESET: begin
                    // Game reset wins over any in-flight frame work, including
                    // a commit: pending bars stay pending.
                    state_d  = ST_IDLE;
                    ybar1_d  = ybar1_q;
                    ybar2_d  = ybar2_q;
                    pend1_d  = pend1_q;
                    pend2_d  = pend2_q;
                    score1_d = '0;
                    score2_d = '0;
                    ball_x_d = X_CENTER;
                    ball_y_d = Y_CENTER;
                    dx_neg_d = 1'b0;
                    dy_neg_d = 1'b0;
                end
                default: result_d = '0;
            endcase
        end
    end

    // State registers: every flop has an asynchronous reset value.
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            result_q  <= '0;
            ybar1_q   <= YBAR_INIT;
            ybar2_q   <= YBAR_INIT;
            shadow1_q <= YBAR_INIT;
            shadow2_q <= YBAR_INIT;
            pend1_q   <= 1'b0;
            pend2_q   <= 1'b0;
            score1_q  <= '0;
            score2_q  <= '0;
            ball_x_q  <= X_CENTER;
            ball_y_q  <= Y_CENTER;
            dx_neg_q  <= 1'b0;
            dy_neg_q  <= 1'b0;
            nx_q      <= '0;
            ny_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            done_q    <= done_d;
            result_q  <= result_d;
            ybar1_q   <= ybar1_d;
            ybar2_q   <= ybar2_d;
            shadow1_q <= shadow1_d;
            shadow2_q <= shadow2_d;
            pend1_q   <= pend1_d;
            pend2_q   <= pend2_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            dx_neg_q  <= dx_neg_d;
            dy_neg_q  <= dy_neg_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
        end
    end

    assign o_done   = done_q;
    assign o_result = result_q;
    assign o_ybar1  = ybar1_q;
    assign o_ybar2  = ybar2_q;
    assign o_ball_x = ball_x_q;
    assign o_ball_y = ball_y_q;

endmodule

// File: doc/pong_frame_ctrl.md
PONG_FRAME_CTRL -- requirements
Module: pong_frame_ctrl

Interface
REQ-001 SHALL have parameter BAR1_X, default 20, meaning left edge of bar 1 in pixels.
REQ-002 SHALL have parameter BAR2_X, default 620, meaning left edge of bar 2 in pixels.
REQ-003 SHALL have parameter BAR_W, default 10, meaning bar width in pixels.
REQ-004 SHALL have parameter BAR_H, default 60, meaning bar height in pixels.
REQ-005 SHALL have parameter BALL_S, default 8, meaning ball side length in pixels.
REQ-006 SHALL have parameter STEP, default 2, meaning ball displacement per frame per axis.
REQ-007 SHALL have port CLK, input, 1, the single clock.
REQ-008 SHALL have port RST_BTN, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port CLK_EN, input, 1, custom-instruction enable.
REQ-010 SHALL have port START, input, 1, custom-instruction start; a command is accepted when CLK_EN and START are both 1.
REQ-011 SHALL have port dataa, input, 32, command word: [31:30] opcode, [9:0] value.
REQ-012 SHALL have port i_frame_end, input, 1, one-cycle strobe from VGA timing at start of vertical blanking.
REQ-013 SHALL have port o_done, output, 1, command completion pulse.
REQ-014 SHALL have port o_result, output, 32, command result.
REQ-015 SHALL have ports o_ybar1 and o_ybar2, output, 10 each, committed bar top coordinates.
REQ-016 SHALL have ports o_ball_x (10) and o_ball_y (9), output, ball top-left corner.

Function
REQ-017 Opcodes SHALL be: 00 write bar 1, 01 write bar 2, 10 read status, 11 reset game.
REQ-018 Bar writes SHALL clamp value to 0..(480-BAR_H), i.e. 420 by default, and store it in a shadow register with the corresponding pending flag set.
REQ-019 A repeated write before commit SHALL overwrite the shadow; last write wins.
REQ-020 o_done SHALL pulse high for exactly one cycle, one cycle after acceptance; o_result is valid in that cycle.
REQ-021 o_result for bar writes SHALL be the clamped value zero-extended.
REQ-022 o_result for status SHALL be: [31:28] score1, [27:24] score2, [23:22] 0, [21] pend2, [20] pend1, [19:10] o_ybar2, [9:0] o_ybar1.
REQ-023 Reset game SHALL, in the following cycle, zero both scores, center the ball (x=316, y=236), set direction dx=+ and dy=+, and force the FSM to IDLE; o_result = 0.
REQ-024 The FSM SHALL have states IDLE, COMMIT, MOVE, BOUNCE, each lasting one cycle after IDLE: IDLE->COMMIT on i_frame_end, COMMIT->MOVE->BOUNCE->IDLE unconditionally.
REQ-025 i_frame_end outside IDLE SHALL be ignored.
REQ-026 COMMIT SHALL copy each pending shadow to o_ybarN and clear its pending flag.
REQ-027 A bar write accepted in the same cycle as COMMIT SHALL remain pending and commit at the next frame.
REQ-028 MOVE SHALL compute next position x +/- STEP, y +/- STEP using 11-bit signed intermediates, with no wrap-around.
REQ-029 In BOUNCE, vertical checks: next y <= 0 -> y=0, dy=+; next y >= 480-BALL_S (472) -> y=472, dy=-.
REQ-030 In BOUNCE with dx=-, if next x <= BAR1_X+BAR_W (30) and the ball overlaps bar 1 vertically (y+BALL_S > ybar1 and y < ybar1+BAR_H), then x=30 and dx=+.
REQ-031 In BOUNCE with dx=+, if next x+BALL_S >= BAR2_X (x >= 612) and the ball overlaps bar 2, then x=612 and dx=-.
REQ-032 The bar checks SHALL take priority over miss checks.
REQ-033 Miss: next x <= 0 SHALL increment score2; next x >= 640-BALL_S (632) SHALL increment score1; on either miss the ball is centered with dx reversed and dy kept.
REQ-034 Scores SHALL be 4 bits and saturate at 15.
REQ-035 A reset-game command concurrent with any FSM state SHALL take priority over BOUNCE/COMMIT updates.

Reset
REQ-036 While RST_BTN=0, all of the following SHALL hold immediately (asynchronously): FSM IDLE; o_done=0; o_result=0; o_ybar1=o_ybar2=210; shadows=210; pending=0; scores=0; ball (316,236); dx=+, dy=+.

Verification
REQ-037 Clamp: write bar1 value 1000 -> o_done after 1 cycle, o_result=420; after i_frame_end + 1 cycle, o_ybar1=420 and pend1=0.
REQ-038 Deferral: write bar2=100 with no frame_end -> status reports pend2=1 and o_ybar2=210; after frame_end, o_ybar2=100.
REQ-039 Collision: ybar1=200, ball at (32,230) with dx=-, one frame -> ball x=30 and dx=+; score unchanged.
REQ-040 Miss: ybar2=0, ball at (630,300) with dx=+ -> score1=1 and ball at (316,236) with dx=-.
REQ-041 Wall and saturation: ball y=2 with dy=- -> y=0, dy=+; 16 consecutive misses -> score1 stays 15.
REQ-042 Async reset mid-BOUNCE, and a write during COMMIT -> reset values appear without a clock edge; the write commits on the following frame.
